pool_window_buffer: RTL and testbench
=====================================

Name: pool_window_buffer

Overview:
Upstream feeder for the 2x2 max-pooling stage. It accepts a row-major raster stream of 16-bit signed feature-map pixels from the convolution stage and buffers one line. For each non-overlapping 2x2 window, with stride 2, it emits the four pixels in parallel on the same cycle, so the pooling stage can consume one window per valid pulse.

Parameters:
DATA_WIDTH, 16, pixel width in bits (two's complement).
IMG_WIDTH, 8, pixels per row; must be even and >= 2.
IMG_HEIGHT, 8, rows per frame; must be even and >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  in_data carries a pixel this cycle.
in_data  input  DATA_WIDTH  pixel value, raster order (row 0 col 0 first).
win_valid  output  1  one-cycle pulse; out1..out4 hold a complete window.
out1  output  DATA_WIDTH  top-left pixel (row 2r, col 2c).
out2  output  DATA_WIDTH  top-right pixel (row 2r, col 2c+1).
out3  output  DATA_WIDTH  bottom-left pixel (row 2r+1, col 2c).
out4  output  DATA_WIDTH  bottom-right pixel (row 2r+1, col 2c+1).
frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Single clock clk. Reset is synchronous and active-high, named reset. On reset: win_valid=0, frame_done=0, out1..out4=0, col/row counters=0, prev-pixel register=0. Line buffer contents are not cleared (don't-care).
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1.
  - They advance only on cycles with in_valid=1.
  - col wraps to 0 at the end of a row, and row then increments.
  - row wraps to 0 after the last pixel of the frame, so back-to-back frames need no gap.
- Even rows: each accepted pixel is written to line_buf[col]. No output.
- Odd rows:
  - Even col: the accepted pixel is stored in the prev-pixel register.
  - Odd col: the window is formed as out1=line_buf[col-1], out2=line_buf[col], out3=prev, out4=in_data.
- Latency: outputs are registered. win_valid and out1..out4 update on the clock edge after the bottom-right pixel is accepted (1-cycle latency).
- out1..out4 hold their values until the next window. win_valid is high for exactly one cycle per window.
- Throughput: IMG_WIDTH/2 × IMG_HEIGHT/2 windows per frame. At most one window every 2 input pixels.
- in_valid gaps: counters, buffer and prev hold. No outputs are generated during a gap.
- frame_done=1 in the same cycle as win_valid for the window at row=IMG_HEIGHT-1, col=IMG_WIDTH-1. Otherwise frame_done=0.
- No backpressure: the downstream stage must accept every window.
- Values pass through bit-exact; there is no arithmetic on data.
- Reset asserted mid-frame:
  - Next cycle is at row 0 col 0, with no pending window.
  - A pixel presented with in_valid in the reset cycle is discarded.
- Memory: line buffer has IMG_WIDTH × DATA_WIDTH entries. It is written on even rows and read on odd rows only, so there is no read/write hazard.

Optional Feature:
POOL_WIN_RELU_EN
- Defined: ReLU is fused at the input. Any accepted pixel with its MSB set (negative) is replaced by 0 before being stored or output. Non-negative pixels pass unchanged.
- Undefined: pixels pass unmodified, including negative values.
- Timing and counters are identical in both builds.

Test Plan:
- Ordering: IMG_WIDTH=4, IMG_HEIGHT=4, reset for 2 cycles, stream 0..15 with continuous in_valid.
  - Expect 4 win_valid pulses with (out1..out4) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15).
  - Each pulse occurs 1 cycle after pixels 5, 7, 13, 15 are accepted.
  - frame_done pulses only with the (10,11,14,15) window.
- Gaps: same stream with in_valid deasserted on every other cycle → identical windows and values, with pulses shifted to 1 cycle after the respective accepts.
- Back-to-back frames: stream 0..15 then 100..115 with no gap.
  - Second frame windows: (100,101,104,105) … (110,111,114,115).
  - Two frame_done pulses in total.
- Mid-frame reset: reset after pixel 6 of frame 0 is accepted, then stream 20..35.
  - First window is (20,21,24,25).
  - No window containing pre-reset data appears.
- Signed values, default 8x8: window pixels 16'hE003, 16'hFFFF, 16'hFFFE, 16'hFFFC.
  - Without POOL_WIN_RELU_EN: the same four values are output unchanged.
  - With POOL_WIN_RELU_EN: all four outputs are 0.
  - A window with 16'h0004 and 16'hFFFE yields 16'h0004 and 0.

Source files
------------

// File: rtl/pool_window_buffer.sv
// pool_window_buffer: one-line buffer forming stride-2 2x2 windows from a raster stream; optional POOL_WIN_RELU_EN fuses ReLU at the input
module pool_window_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  win_valid,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic                  frame_done
);
  localparam int CW = IMG_WIDTH > 2 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 2 ? $clog2(IMG_HEIGHT) : 1;
  logic [DATA_WIDTH-1:0] line_buf [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] prev, px;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic last_col, last_row, win;
`ifdef POOL_WIN_RELU_EN
  assign px = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign px = in_data;
`endif
  assign last_col = col == CW'(IMG_WIDTH - 1);
  assign last_row = row == RW'(IMG_HEIGHT - 1);
  assign win = in_valid && row[0] && col[0];
  // Raster counters, prev pixel and registered window outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      prev <= '0;
      win_valid <= 1'b0;
      frame_done <= 1'b0;
      out1 <= '0;
      out2 <= '0;
      out3 <= '0;
      out4 <= '0;
    end else begin
      win_valid <= win;
      frame_done <= win && last_col && last_row;
      if (in_valid) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? (last_row ? '0 : row + 1'b1) : row;
        if (row[0] && !col[0]) prev <= px;
      end
      if (win) begin
        out1 <= line_buf[col ^ CW'(1)];
        out2 <= line_buf[col];
        out3 <= prev;
        out4 <= px;
      end
    end
  end
  // Top row of each window pair is captured on even rows; contents need no reset
  always_ff @(posedge clk) begin
    if (!reset && in_valid && !row[0]) line_buf[col] <= px;
  end
endmodule

// File: tb/tb_pool_window_buffer.sv
// tb_pool_window_buffer: frame-array model checks a 4x4 and a default 8x8 instance every cycle
module tb_pool_window_buffer;
  logic clk = 0, reset = 1, in_valid = 0;
  logic [15:0] in_data = '0;
  logic wv [2], fd [2];
  logic [15:0] o1 [2], o2 [2], o3 [2], o4 [2];
  int checks = 0, failures = 0;
  logic [15:0] fr [2][8][8];
  int n [2];
  logic ev [2], efd [2];
  logic [15:0] e1 [2], e2 [2], e3 [2], e4 [2];
  logic [63:0] log0 [$], log1 [$];
  int fdc0 = 0, fdc1 = 0;
  logic [15:0] sig [64];
  logic [63:0] neg_win, mix_win;
  always #5 clk = ~clk;
  pool_window_buffer #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .win_valid(wv[0]),
    .out1(o1[0]), .out2(o2[0]), .out3(o3[0]), .out4(o4[0]), .frame_done(fd[0]));
  pool_window_buffer u8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .win_valid(wv[1]),
    .out1(o1[1]), .out2(o2[1]), .out3(o3[1]), .out4(o4[1]), .frame_done(fd[1]));
  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef POOL_WIN_RELU_EN
    return $signed(v) < 0 ? 16'h0 : v;
`else
    return v;
`endif
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: pixel index -> (row, col) in a full frame image; window completes at odd row, odd col
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w, h, r, c;
      w = k ? 8 : 4;
      h = w;
      if (reset) begin
        n[k] = 0; ev[k] = 0; efd[k] = 0;
        e1[k] = 0; e2[k] = 0; e3[k] = 0; e4[k] = 0;
      end else begin
        ev[k] = 0; efd[k] = 0;
        if (in_valid) begin
          r = n[k] / w;
          c = n[k] % w;
          fr[k][r][c] = relu(in_data);
          if (r % 2 == 1 && c % 2 == 1) begin
            ev[k] = 1;
            efd[k] = n[k] == w * h - 1;
            e1[k] = fr[k][r-1][c-1]; e2[k] = fr[k][r-1][c];
            e3[k] = fr[k][r][c-1];   e4[k] = fr[k][r][c];
          end
          n[k] = (n[k] + 1) % (w * h);
        end
      end
    end
  end
  // Compare both instances against the model every cycle and log observed windows
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk(k ? "win_valid8" : "win_valid4", 64'(wv[k]), 64'(ev[k]));
      chk(k ? "frame_done8" : "frame_done4", 64'(fd[k]), 64'(efd[k]));
      chk(k ? "outs8" : "outs4", {o1[k], o2[k], o3[k], o4[k]}, {e1[k], e2[k], e3[k], e4[k]});
    end
    if (wv[0]) log0.push_back({o1[0], o2[0], o3[0], o4[0]});
    if (wv[1]) log1.push_back({o1[1], o2[1], o3[1], o4[1]});
    if (fd[0]) fdc0++;
    if (fd[1]) fdc1++;
  end
  task automatic send(input logic [15:0] v, input logic vl);
    @(posedge clk); #1;
    in_valid = vl;
    in_data = v;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; in_valid = 1; in_data = 16'h7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0; in_valid = 0;
    @(negedge clk);
    log0.delete(); log1.delete(); fdc0 = 0; fdc1 = 0;
  endtask
  task automatic stream(input int base, input int cnt, input bit gap);
    for (int i = 0; i < cnt; i++) begin
      send(16'(base + i), 1);
      if (gap) send(16'h5555, 0);
    end
    send(16'h0, 0);
    repeat (3) send(16'h0, 0);
  endtask
  initial begin
    do_reset();
    chk("reset_outs", {o1[0], o2[0], o3[0], o4[0]}, 64'h0);
    chk("reset_valid", 64'({wv[0], fd[0]}), 64'h0);
    stream(0, 16, 0);
    chk("ord_count", 64'(log0.size()), 64'd4);
    chk("ord_w0", log0[0], {16'd0, 16'd1, 16'd4, 16'd5});
    chk("ord_w1", log0[1], {16'd2, 16'd3, 16'd6, 16'd7});
    chk("ord_w2", log0[2], {16'd8, 16'd9, 16'd12, 16'd13});
    chk("ord_w3", log0[3], {16'd10, 16'd11, 16'd14, 16'd15});
    chk("ord_fd", 64'(fdc0), 64'd1);
    do_reset();
    stream(0, 16, 1);
    chk("gap_count", 64'(log0.size()), 64'd4);
    chk("gap_w0", log0[0], {16'd0, 16'd1, 16'd4, 16'd5});
    chk("gap_w3", log0[3], {16'd10, 16'd11, 16'd14, 16'd15});
    chk("gap_fd", 64'(fdc0), 64'd1);
    do_reset();
    for (int i = 0; i < 16; i++) send(16'(i), 1);
    stream(100, 16, 0);
    chk("b2b_count", 64'(log0.size()), 64'd8);
    chk("b2b_w4", log0[4], {16'd100, 16'd101, 16'd104, 16'd105});
    chk("b2b_w7", log0[7], {16'd110, 16'd111, 16'd114, 16'd115});
    chk("b2b_fd", 64'(fdc0), 64'd2);
    do_reset();
    for (int i = 0; i < 7; i++) send(16'(i), 1);
    do_reset();
    stream(20, 16, 0);
    chk("mid_count", 64'(log0.size()), 64'd4);
    chk("mid_w0", log0[0], {16'd20, 16'd21, 16'd24, 16'd25});
    chk("mid_w3", log0[3], {16'd30, 16'd31, 16'd34, 16'd35});
    do_reset();
    for (int i = 0; i < 64; i++) sig[i] = 16'(i);
    sig[0] = 16'hE003; sig[1] = 16'hFFFF; sig[8] = 16'hFFFE; sig[9] = 16'hFFFC;
    sig[2] = 16'h0004; sig[3] = 16'hFFFE;
    for (int i = 0; i < 64; i++) send(sig[i], 1);
    repeat (3) send(16'h0, 0);
`ifdef POOL_WIN_RELU_EN
    neg_win = 64'h0;
    mix_win = {16'h0004, 16'h0000, 16'd10, 16'd11};
`else
    neg_win = {16'hE003, 16'hFFFF, 16'hFFFE, 16'hFFFC};
    mix_win = {16'h0004, 16'hFFFE, 16'd10, 16'd11};
`endif
    chk("sig_count", 64'(log1.size()), 64'd16);
    chk("sig_neg", log1[0], neg_win);
    chk("sig_mix", log1[1], mix_win);
    chk("sig_fd", 64'(fdc1), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
